filterbank_matrix_ctrl: RTL and testbench
=========================================

FILTERBANK_MATRIX_CTRL -- requirements
Module: filterbank_matrix_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock (rising edge); reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL have ports: start  in  1  one-cycle pulse, begin one 64x32 matrixing pass; busy  out  1  pass in progress; done  out  1  one-cycle pulse, pass complete.
REQ-003 SHALL have ports: smp_rd_en  out  1  sample-buffer read enable; smp_addr  out  5  subband index k; smp_data  in  18  signed subband sample, Q1.16.
REQ-004 SHALL have ports: rom_en  out  1  cosine ROM enable; rom_i  out  6  row i; rom_k  out  5  column k; rom_data  in  18  signed cosine coefficient, Q1.16.
REQ-005 SHALL have ports: v_wr_en  out  1  V-buffer write strobe; v_addr  out  6  V index i; v_data  out  18  signed V[i], Q1.16.
REQ-006 SHALL have parameters: N_I default 64, number of rows; N_K default 32, terms per row.

Function
REQ-007 SHALL compute V[i] = sum over k=0..31 of rom[i][k]*S[k] for i=0..63, in increasing i, and for each i in increasing k.
REQ-008 SHALL treat ROM and sample buffer as synchronous: data valid exactly one cycle after the address cycle with enable high.
REQ-009 SHALL use FSM states IDLE, RUN, FLUSH, DONE: IDLE->RUN on start; RUN->FLUSH after address (63,31) is issued; FLUSH->DONE after the write of V[63]; DONE->IDLE unconditionally after one cycle.
REQ-010 SHALL, with start sampled high in cycle 0, issue address (i,k) in cycle 1+32i+k, with smp_rd_en=rom_en=1 and smp_addr=rom_k=k, rom_i=i; no bubbles between rows.
REQ-011 SHALL register the 36-bit signed product in cycle c+2 for address cycle c, and update a 41-bit signed accumulator in cycle c+3: load on k=0, add on k>0.
REQ-012 SHALL produce v_data = accumulator arithmetically shifted right by 16 (truncation), saturated to [-131072, 131071], registered.
REQ-013 SHALL assert v_wr_en with v_addr=i for exactly one cycle, in cycle 32i+36; last write in cycle 2052.
REQ-014 SHALL hold busy high in cycles 1..2052 and pulse done in cycle 2053 with busy low.
REQ-015 SHALL ignore start while busy or in DONE; a start in the cycle after done begins a new pass.
REQ-016 SHALL hold smp_rd_en, rom_en and v_wr_en low in IDLE, FLUSH (except the v_wr_en strobes) and DONE; address outputs SHALL be don't-care when enables are low.
REQ-017 SHALL wrap k from 31 to 0 and increment i in the same cycle; i SHALL not wrap past 63 within a pass.

Reset
REQ-018 SHALL, on reset high, asynchronously enter IDLE and clear counters, accumulator, product register, busy, done, all enables and v_data to 0.
REQ-019 SHALL abort a pass on reset mid-operation with no further writes or done; next pass requires a new start after reset deasserts.

Structure
REQ-020 SHALL place N_I, N_K, sample/coefficient width (18), fraction bits (16), accumulator width (41) and FSM state encoding in the shared filterbank package.
REQ-021 SHALL use one sub-module, fb_mac (registered multiply, accumulate with load/add control, shift-and-saturate output); FSM and counters stay in the top module.

Verification
REQ-022 All samples 0, ROM model arbitrary -> 64 writes, v_data=0 each, v_addr 0..63 in cycles 36,68,..,2052, done in cycle 2053.
REQ-023 S[0]=65536 (1.0), others 0; ROM model rom[i][k]=i*1024-k -> V[i]=i*1024.
REQ-024 All S[k]=131071, all rom=131071 -> every V[i] saturates to 131071; all rom=-131072 -> every V[i]=-131072.
REQ-025 Start pulses in cycles 0, 500 and 2053 -> second ignored (exactly 64 writes in first pass); third starts a second pass with first write in cycle 2089.
REQ-026 Reset asserted in cycle 1000 for 2 cycles -> all outputs 0 immediately, no writes or done afterwards; new start yields a correct full pass.

Source files
------------

// File: rtl/filterbank_matrix_ctrl_pkg.sv
// Shared definitions for the filterbank matrixing engine.
// Holds the matrix dimensions, datapath widths, FSM state encoding and
// the shift-and-saturate helper that converts the accumulator to Q1.16.
package filterbank_matrix_ctrl_pkg;

    localparam int FB_N_I       = 64;  // rows (V outputs) per pass
    localparam int FB_N_K       = 32;  // terms (subband samples) per row
    localparam int DATA_W       = 18;  // sample / coefficient / V width, Q1.16
    localparam int FRAC_W       = 16;  // fraction bits of the Q1.16 format
    localparam int PROD_W       = 2 * DATA_W;  // full signed product width
    localparam int ACC_W        = 41;  // product width plus log2(FB_N_K) guard bits
    localparam int IDX_I_W      = 6;   // width of row index i
    localparam int IDX_K_W      = 5;   // width of column index k

    // Register stages between the last address cycle and the V write strobe:
    // data fetch, product register, accumulator register.
    localparam int FLUSH_CYCLES = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } fb_state_e;

    localparam logic signed [ACC_W-1:0]  ACC_SAT_MAX = 41'sd131071;
    localparam logic signed [ACC_W-1:0]  ACC_SAT_MIN = -41'sd131072;
    localparam logic signed [DATA_W-1:0] V_MAX       = 18'sh1FFFF;
    localparam logic signed [DATA_W-1:0] V_MIN       = 18'sh20000;

    // Drop the extra fraction bits of the Q2.32 sum (truncation toward
    // minus infinity) and clamp into the 18-bit Q1.16 range.
    function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        shifted = acc >>> FRAC_W;
        if (shifted > ACC_SAT_MAX) begin
            return V_MAX;
        end else if (shifted < ACC_SAT_MIN) begin
            return V_MIN;
        end else begin
            return shifted[DATA_W-1:0];
        end
    endfunction

endpackage

// File: rtl/filterbank_matrix_ctrl_mac.sv
// fb_mac: multiply-accumulate datapath of the matrixing engine.
// Control inputs are given in the address cycle; they are delayed here so
// they line up with the synchronous ROM/sample data one cycle later.
//   clk, reset        clock, asynchronous active-high reset
//   issue_i           address issued this cycle
//   first_i, last_i   issued address is k = 0 / k = last term of the row
//   row_i             row index i of the issued address
//   coef_i, smp_i     ROM coefficient and subband sample (valid one cycle after issue)
//   wr_en_o, addr_o   one-cycle V write strobe and its row index
//   data_o            shifted and saturated V value, Q1.16
module fb_mac
    import filterbank_matrix_ctrl_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_i,
    input  logic                      first_i,
    input  logic                      last_i,
    input  logic [IDX_I_W-1:0]        row_i,
    input  logic signed [DATA_W-1:0]  coef_i,
    input  logic signed [DATA_W-1:0]  smp_i,
    output logic                      wr_en_o,
    output logic [IDX_I_W-1:0]        addr_o,
    output logic signed [DATA_W-1:0]  data_o
);

    // Stage 1: data arrives from the memories
    logic               s1_valid_q, s1_first_q, s1_last_q;
    logic [IDX_I_W-1:0] s1_row_q;
    // Stage 2: product register
    logic               s2_valid_q, s2_first_q, s2_last_q;
    logic [IDX_I_W-1:0] s2_row_q;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    // Stage 3: accumulator register
    logic               s3_valid_q, s3_last_q;
    logic [IDX_I_W-1:0] s3_row_q;
    logic signed [ACC_W-1:0] acc_q, acc_d, prod_ext;
    // Output register
    logic                     wr_en_q;
    logic [IDX_I_W-1:0]       addr_q;
    logic signed [DATA_W-1:0] data_q;

    // Product and accumulate next-state; the first term of a row reloads
    // the accumulator so rows never need an explicit clear cycle.
    always_comb begin
        prod_d   = PROD_W'(coef_i) * PROD_W'(smp_i);
        prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
        acc_d    = acc_q;
        if (s2_valid_q) begin
            acc_d = s2_first_q ? prod_ext : acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_row_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_row_q   <= '0;
            prod_q     <= '0;
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
            s3_row_q   <= '0;
            acc_q      <= '0;
            wr_en_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            s1_valid_q <= issue_i;
            s1_first_q <= first_i;
            s1_last_q  <= last_i;
            s1_row_q   <= row_i;

            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_row_q   <= s1_row_q;
            if (s1_valid_q) begin
                prod_q <= prod_d;
            end

            s3_valid_q <= s2_valid_q;
            s3_last_q  <= s2_last_q;
            s3_row_q   <= s2_row_q;
            acc_q      <= acc_d;

            // The accumulator holds the complete row sum right after the last term.
            wr_en_q <= s3_valid_q & s3_last_q;
            addr_q  <= s3_row_q;
            if (s3_valid_q && s3_last_q) begin
                data_q <= sat_shift(acc_q);
            end
        end
    end

    assign wr_en_o = wr_en_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/filterbank_matrix_ctrl.sv
// filterbank_matrix_ctrl: sequences one 64x32 matrixing pass
// V[i] = sum_k rom[i][k] * S[k], streaming one (i,k) address per cycle.
//   clk, reset                      clock, asynchronous active-high reset
//   start, busy, done               pass handshake (start/done are one-cycle pulses)
//   smp_rd_en, smp_addr, smp_data   synchronous subband sample buffer port
//   rom_en, rom_i, rom_k, rom_data  synchronous cosine ROM port
//   v_wr_en, v_addr, v_data         V-buffer write port
module filterbank_matrix_ctrl
    import filterbank_matrix_ctrl_pkg::*;
#(
    parameter int N_I = FB_N_I,
    parameter int N_K = FB_N_K
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      smp_rd_en,
    output logic [IDX_K_W-1:0]        smp_addr,
    input  logic signed [DATA_W-1:0]  smp_data,
    output logic                      rom_en,
    output logic [IDX_I_W-1:0]        rom_i,
    output logic [IDX_K_W-1:0]        rom_k,
    input  logic signed [DATA_W-1:0]  rom_data,
    output logic                      v_wr_en,
    output logic [IDX_I_W-1:0]        v_addr,
    output logic signed [DATA_W-1:0]  v_data
);

    localparam logic [IDX_I_W-1:0] I_LAST = IDX_I_W'(N_I - 1);
    localparam logic [IDX_K_W-1:0] K_LAST = IDX_K_W'(N_K - 1);

    fb_state_e          state_q;
    logic [IDX_I_W-1:0] i_q;
    logic [IDX_K_W-1:0] k_q;
    logic               rd_en_q;
    logic               busy_q;
    logic               done_q;
    logic [1:0]         flush_q;

    // Pass sequencer. busy rises with the first address and drops together
    // with the done pulse, so the DONE state is the last busy cycle and the
    // following cycle (done high) already accepts a new start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            k_q     <= '0;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            flush_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        i_q     <= '0;
                        k_q     <= '0;
                        rd_en_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (i_q == I_LAST && k_q == K_LAST) begin
                        rd_en_q <= 1'b0;
                        flush_q <= '0;
                        state_q <= FLUSH;
                    end else if (k_q == K_LAST) begin
                        k_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                FLUSH: begin
                    // Leave once the final row sum has reached the V write register.
                    if (flush_q == 2'(FLUSH_CYCLES - 1)) begin
                        state_q <= DONE;
                    end else begin
                        flush_q <= flush_q + 1'b1;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    fb_mac u_mac (
        .clk     (clk),
        .reset   (reset),
        .issue_i (rd_en_q),
        .first_i (k_q == '0),
        .last_i  (k_q == K_LAST),
        .row_i   (i_q),
        .coef_i  (rom_data),
        .smp_i   (smp_data),
        .wr_en_o (v_wr_en),
        .addr_o  (v_addr),
        .data_o  (v_data)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign smp_rd_en = rd_en_q;
    assign rom_en    = rd_en_q;
    assign smp_addr  = k_q;
    assign rom_k     = k_q;
    assign rom_i     = i_q;

endmodule

// File: tb/tb_filterbank_matrix_ctrl.sv
// Directed bench for filterbank_matrix_ctrl with behavioural synchronous
// ROM and sample buffer models. Cycle 0 is the cycle in which start is
// sampled high; write timing, data, done and busy are checked per pass.
module tb_filterbank_matrix_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic busy, done;
    logic smp_rd_en, rom_en, v_wr_en;
    logic [4:0] smp_addr, rom_k;
    logic [5:0] rom_i, v_addr;
    logic signed [17:0] smp_data = '0;
    logic signed [17:0] rom_data = '0;
    logic signed [17:0] v_data;

    int checkCount = 0;
    int errCount   = 0;

    int edgeCnt  = 0;
    int passBase = 0;
    int cycNow;
    assign cycNow = edgeCnt - passBase;

    int wrCount = 0, doneCnt = 0, doneCyc = 0, busyCnt = 0, lastBusy = 0;
    int romCnt = 0, addrErr = 0;
    int doneBusy = 0;
    int wrAddr[1024];
    int wrData[1024];
    int wrCyc[1024];

    int wrBase, doneBase, busyBase, romBase, errBase;

    int romMode = 0;
    logic signed [17:0] smpMem[32];
    int expV[64];

    always #5 clk = ~clk;

    filterbank_matrix_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .smp_rd_en (smp_rd_en),
        .smp_addr  (smp_addr),
        .smp_data  (smp_data),
        .rom_en    (rom_en),
        .rom_i     (rom_i),
        .rom_k     (rom_k),
        .rom_data  (rom_data),
        .v_wr_en   (v_wr_en),
        .v_addr    (v_addr),
        .v_data    (v_data)
    );

    // Cosine ROM contents selected by romMode
    function automatic logic signed [17:0] romVal(input int i, input int k);
        int v;
        case (romMode)
            0:       v = i * 1024 - k;
            1:       v = 131071;
            2:       v = -131072;
            default: v = i * 37 + k * 11 - 500;
        endcase
        return 18'(v);
    endfunction

    // Synchronous memory models: data appears one cycle after the enable
    always @(posedge clk) begin
        edgeCnt <= edgeCnt + 1;
        if (rom_en) rom_data <= romVal(int'(rom_i), int'(rom_k));
        if (smp_rd_en) smp_data <= smpMem[smp_addr];
    end

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (v_wr_en && wrCount < 1024) begin
            wrAddr[wrCount] <= int'(v_addr);
            wrData[wrCount] <= int'(v_data);
            wrCyc[wrCount]  <= cycNow;
            wrCount         <= wrCount + 1;
        end
        if (done) begin
            doneCnt  <= doneCnt + 1;
            doneCyc  <= cycNow;
            doneBusy <= int'(busy);
        end
        if (busy) begin
            busyCnt  <= busyCnt + 1;
            lastBusy <= cycNow;
        end
        if (rom_en) begin
            romCnt <= romCnt + 1;
            if (!smp_rd_en || smp_addr != rom_k ||
                cycNow != 1 + 32 * int'(rom_i) + int'(rom_k))
                addrErr <= addrErr + 1;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Pulse start for one cycle; the cycle it is sampled in becomes cycle 0
    task automatic applyStimulus();
        passBase = edgeCnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic snap();
        wrBase   = wrCount;
        doneBase = doneCnt;
        busyBase = busyCnt;
        romBase  = romCnt;
        errBase  = addrErr;
    endtask

    task automatic waitDone(input int target, input int budget, input string tag);
        int n = 0;
        while (doneCnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " done seen"}, (doneCnt >= target) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic checkPass(input string tag);
        checkOutput({tag, " write count"}, wrCount - wrBase, 64);
        for (int n = 0; n < 64; n++) begin
            checkOutput($sformatf("%s v_addr[%0d]", tag, n), wrAddr[wrBase + n], n);
            checkOutput($sformatf("%s wr cycle[%0d]", tag, n), wrCyc[wrBase + n], 36 + 32 * n);
            checkOutput($sformatf("%s v_data[%0d]", tag, n), wrData[wrBase + n], expV[n]);
        end
        checkOutput({tag, " done count"}, doneCnt - doneBase, 1);
        checkOutput({tag, " done cycle"}, doneCyc, 2053);
        checkOutput({tag, " busy at done"}, doneBusy, 0);
        checkOutput({tag, " busy cycles"}, busyCnt - busyBase, 2052);
        checkOutput({tag, " last busy"}, lastBusy, 2052);
        checkOutput({tag, " addr cycles"}, romCnt - romBase, 2048);
        checkOutput({tag, " addr errors"}, addrErr - errBase, 0);
    endtask

    task automatic runPass(input string tag);
        snap();
        applyStimulus();
        waitDone(doneBase + 1, 2300, tag);
        checkPass(tag);
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " busy"}, int'(busy), 0);
        checkOutput({tag, " done"}, int'(done), 0);
        checkOutput({tag, " v_wr_en"}, int'(v_wr_en), 0);
        checkOutput({tag, " rom_en"}, int'(rom_en), 0);
        checkOutput({tag, " smp_rd_en"}, int'(smp_rd_en), 0);
        checkOutput({tag, " v_data"}, int'(v_data), 0);
    endtask

    initial begin
        int early;
        reset = 1'b1;
        start = 1'b0;
        for (int k = 0; k < 32; k++) smpMem[k] = '0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // All samples zero, arbitrary ROM
        romMode = 3;
        for (int i = 0; i < 64; i++) expV[i] = 0;
        runPass("zero");

        // S[0] = 1.0, rom[i][k] = i*1024-k -> V[i] = i*1024
        romMode = 0;
        smpMem[0] = 18'sd65536;
        for (int i = 0; i < 64; i++) expV[i] = i * 1024;
        runPass("unit");

        // Positive saturation
        romMode = 1;
        for (int k = 0; k < 32; k++) smpMem[k] = 18'sd131071;
        for (int i = 0; i < 64; i++) expV[i] = 131071;
        runPass("satpos");

        // Negative saturation
        romMode = 2;
        for (int i = 0; i < 64; i++) expV[i] = -131072;
        runPass("satneg");

        // S[1] = -1 LSB: tiny negative sums truncate to -1, row 0 sum is +1 -> 0
        romMode = 0;
        for (int k = 0; k < 32; k++) smpMem[k] = '0;
        smpMem[1] = -18'sd1;
        for (int i = 0; i < 64; i++) expV[i] = (i == 0) ? 0 : -1;
        runPass("trunc");

        // Start at 0 (accepted), 500 (ignored), 2053 (next pass)
        smpMem[1] = '0;
        smpMem[0] = 18'sd65536;
        for (int i = 0; i < 64; i++) expV[i] = i * 1024;
        snap();
        applyStimulus();
        while (cycNow < 500) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cycNow < 2053 && cycNow < 5000) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(doneBase + 2, 2300, "restart");
        early = 0;
        for (int n = wrBase; n < wrCount; n++) if (wrCyc[n] <= 2052) early++;
        checkOutput("restart first-pass writes", early, 64);
        checkOutput("restart total writes", wrCount - wrBase, 128);
        checkOutput("restart second first cycle", wrCyc[wrBase + 64], 2089);
        checkOutput("restart second first addr", wrAddr[wrBase + 64], 0);
        checkOutput("restart second last cycle", wrCyc[wrBase + 127], 4105);
        checkOutput("restart second last data", wrData[wrBase + 127], 64512);
        checkOutput("restart done count", doneCnt - doneBase, 2);
        checkOutput("restart last done cycle", doneCyc, 4106);
        checkOutput("restart busy cycles", busyCnt - busyBase, 4104);

        // Reset in cycle 1000 for two cycles aborts the pass
        snap();
        applyStimulus();
        while (cycNow < 1000) @(negedge clk);
        checkOutput("abort writes before reset", wrCount - wrBase, 31);
        reset = 1'b1;
        #1;
        checkIdleOutputs("abort");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        snap();
        repeat (1200) @(negedge clk);
        checkOutput("abort writes after", wrCount - wrBase, 0);
        checkOutput("abort done after", doneCnt - doneBase, 0);
        checkOutput("abort busy after", busyCnt - busyBase, 0);

        // Full pass after the abort
        romMode = 1;
        for (int k = 0; k < 32; k++) smpMem[k] = 18'sd131071;
        for (int i = 0; i < 64; i++) expV[i] = 131071;
        runPass("postabort");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
        $finish;
    end

endmodule
